// File: rtl/mem_access_ctrl.sv
// Sequencer between the MEM stage and the data cache port. Drives one
// dbus request per load/store, stalls the pipeline while it is outstanding,
// places store bytes on their lanes and extends load results.
//
// Handshake: dreq.valid rises in BUSY and stays high with every field
// constant until dresp.data_ok is seen on a rising edge; addr_ok is ignored.
// On the MEM side, req_valid is held stable while stall=1, and the pipeline
// advances on the single DONE cycle (done=1, stall=0).

package common;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module mem_access_ctrl
    import common::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        misaligned,
    output logic [63:0] rdata,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [63:0] addr_q;
    logic [2:0]  funct3_q;
    logic        write_q;
    logic [63:0] wdata_q;
    logic        err_q;

    logic        req_misalign;
    logic        req_illegal;
    logic        req_err;
    logic        accept;

    logic [63:0] shifted;
    logic [63:0] load_ext;
    logic [7:0]  strobe_base;

    // addr_ok carries no meaning for this sequencer; valid is held until data_ok.
    logic        unused_addr_ok;
    assign unused_addr_ok = dresp.addr_ok;

    assign accept = (state == IDLE) && req_valid;

    // Classify the incoming request: alignment against its size, and funct3 legality.
    always_comb begin
        req_misalign = 1'b0;
        case (req_funct3[1:0])
            2'b00:   req_misalign = 1'b0;
            2'b01:   req_misalign = req_addr[0];
            2'b10:   req_misalign = |req_addr[1:0];
            default: req_misalign = |req_addr[2:0];
        endcase
        req_illegal = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
        req_err     = req_misalign | req_illegal;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        misaligned = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = req_err ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (dresp.data_ok) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                misaligned = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stall is combinational so the request cycle in IDLE already freezes the pipe.
    assign stall = req_valid && (state != DONE);

    // Latch the access when it is accepted; fields stay constant until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            write_q  <= req_write;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
        end
    end

    // Lane select and sign/zero extension of the returning cache data.
    always_comb begin
        shifted  = dresp.data >> {addr_q[2:0], 3'b000};
        load_ext = shifted;
        case (funct3_q[1:0])
            2'b00:   load_ext = funct3_q[2] ? {56'd0, shifted[7:0]}
                                            : {{56{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = funct3_q[2] ? {48'd0, shifted[15:0]}
                                            : {{48{shifted[15]}}, shifted[15:0]};
            2'b10:   load_ext = funct3_q[2] ? {32'd0, shifted[31:0]}
                                            : {{32{shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    // Load result register: cleared by error accesses, untouched by stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (accept && req_err) begin
            rdata <= '0;
        end else if ((state == BUSY) && dresp.data_ok && !write_q) begin
            rdata <= load_ext;
        end
    end

    // Cache request: driven only while BUSY, zero otherwise.
    always_comb begin
        strobe_base = 8'h00;
        case (funct3_q[1:0])
            2'b00:   strobe_base = 8'h01;
            2'b01:   strobe_base = 8'h03;
            2'b10:   strobe_base = 8'h0F;
            default: strobe_base = 8'hFF;
        endcase

        dreq = '0;
        if (state == BUSY) begin
            dreq.valid = 1'b1;
            dreq.addr  = addr_q;
            dreq.size  = msize_t'({1'b0, funct3_q[1:0]});
            if (write_q) begin
                dreq.strobe = strobe_base << addr_q[2:0];
                dreq.data   = wdata_q << {addr_q[2:0], 3'b000};
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized checks of mem_access_ctrl against a byte-level
// reference model of RV64 load/store width rules.
module tb_mem_access_ctrl;
  import common::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        stall;
  logic        done;
  logic        misaligned;
  logic [63:0] rdata;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;

  mem_access_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .misaligned (misaligned),
    .rdata      (rdata),
    .dreq       (dreq),
    .dresp      (dresp)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_rdata = '0;
  msize_t sz_map [4] = '{MSIZE1, MSIZE2, MSIZE4, MSIZE8};

  logic [7:0]  last_strobe;
  logic [63:0] last_data;
  logic [63:0] last_size;
  int          last_stall_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge while the DUT is idle. Returns at the negedge of the
  // completion cycle with req_valid dropped.
  task automatic do_access(input logic wr, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] resp, input int n_wait,
                           input bit flush, output int done_at, output int valid_at);
    int          nbytes;
    int          off;
    bit          err;
    logic [7:0]  e_strobe;
    logic [63:0] e_data;
    logic [63:0] mask;
    logic [63:0] v;
    logic [63:0] exp_r;
    bit          exp_stall;

    nbytes = 1 << f3[1:0];
    off    = int'(addr[2:0]);
    err    = (int'(addr % 64'(nbytes)) != 0) || (wr ? f3[2] : (f3 == 3'b111));
    e_strobe = wr ? 8'(((1 << nbytes) - 1) << off) : 8'h00;
    e_data   = wr ? (wdata << (8 * off)) : 64'd0;
    mask = (nbytes == 8) ? {64{1'b1}} : ((64'd1 << (8 * nbytes)) - 64'd1);
    v = (resp >> (8 * off)) & mask;
    if (!f3[2] && v[8 * nbytes - 1]) v = v | ~mask;

    if (err)      model_rdata = 64'd0;
    else if (!wr) model_rdata = v;
    exp_q.push_back(model_rdata);

    valid_at = -1;
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    #1;
    chk("stall_on_request", stall, 1'b1);
    chk("valid_in_idle", dreq.valid, 1'b0);
    last_stall_cnt = 1;

    if (err) begin
      @(negedge clk);
      chk("err_done", done, 1'b1);
      chk("err_misaligned", misaligned, 1'b1);
      chk("err_no_bus", dreq.valid, 1'b0);
      chk("err_stall", stall, 1'b0);
      exp_r = exp_q.pop_front();
      chk("err_rdata", rdata, exp_r);
      done_at = cyc;
    end else begin
      for (int c = 1; c <= n_wait; c++) begin
        @(negedge clk);
        exp_stall = !(flush && c > 1);
        chk("busy_valid", dreq.valid, 1'b1);
        chk("busy_done", done, 1'b0);
        chk("busy_stall", stall, exp_stall);
        chk("busy_addr", dreq.addr, addr);
        chk("busy_size", 64'(dreq.size), 64'(sz_map[f3[1:0]]));
        chk("busy_strobe", dreq.strobe, e_strobe);
        chk("busy_data", dreq.data, e_data);
        if (stall) last_stall_cnt++;
        if (c == 1) begin
          valid_at    = cyc;
          last_strobe = dreq.strobe;
          last_data   = dreq.data;
          last_size   = 64'(dreq.size);
        end
        if (c == n_wait) begin
          dresp.data_ok = 1'b1;
          dresp.data    = resp;
        end else begin
          dresp.data_ok = 1'b0;
          dresp.data    = {$urandom(), $urandom()};
        end
        if (flush && c == 1) req_valid = 1'b0;
      end
      @(negedge clk);
      dresp.data_ok = 1'b0;
      chk("done_pulse", done, 1'b1);
      chk("done_misaligned", misaligned, 1'b0);
      chk("done_stall", stall, 1'b0);
      chk("done_valid", dreq.valid, 1'b0);
      exp_r = exp_q.pop_front();
      chk("done_rdata", rdata, exp_r);
      done_at = cyc;
    end
    req_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int d0, d1, v0, v1;
  logic [63:0] r_addr, r_wdata, r_resp;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    dresp = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", dreq.valid, 1'b0);
    chk("rst_addr", dreq.addr, 64'd0);
    chk("rst_size", 64'(dreq.size), 64'd0);
    chk("rst_strobe", dreq.strobe, 8'd0);
    chk("rst_data", dreq.data, 64'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_misaligned", misaligned, 1'b0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_stall", stall, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // ld with a 3-cycle cache
    do_access(1'b0, 3'b011, 64'h1000, 64'd0, 64'h1122334455667788, 3, 1'b0, d0, v0);
    chk("ld_size", last_size, 64'(MSIZE8));
    chk("ld_strobe", last_strobe, 8'h00);
    chk("ld_stall_cycles", last_stall_cnt, 4);
    chk("ld_rdata_const", rdata, 64'h1122334455667788);
    @(negedge clk);

    // lb / lbu on byte 3 = 0x80
    do_access(1'b0, 3'b000, 64'h2003, 64'd0, 64'h0000000080000000, 1, 1'b0, d0, v0);
    chk("lb_const", rdata, 64'hFFFFFFFFFFFFFF80);
    @(negedge clk);
    do_access(1'b0, 3'b100, 64'h2003, 64'd0, 64'h0000000080000000, 1, 1'b0, d0, v0);
    chk("lbu_const", rdata, 64'h80);
    @(negedge clk);

    // sh lane placement, rdata left alone
    do_access(1'b1, 3'b001, 64'h3006, 64'hABCD, 64'hDEADBEEF, 2, 1'b0, d0, v0);
    chk("sh_strobe", last_strobe, 8'hC0);
    chk("sh_data", last_data, 64'hABCD000000000000);
    chk("sh_size", last_size, 64'(MSIZE2));
    chk("sh_rdata_kept", rdata, 64'h80);
    @(negedge clk);

    // misaligned lw: done one cycle after the request
    do_access(1'b0, 3'b010, 64'h4002, 64'd0, 64'd0, 1, 1'b0, d0, v0);
    @(negedge clk);

    // reset while BUSY, then a late data_ok
    do_access(1'b0, 3'b011, 64'h4800, 64'd0, 64'h0123456789ABCDEF, 1, 1'b0, d0, v0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b011; req_addr = 64'h5000;
    @(negedge clk);
    chk("rst_mid_busy", dreq.valid, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", dreq.valid, 1'b0);
    chk("rst_mid_rdata", rdata, 64'd0);
    chk("rst_mid_done", done, 1'b0);
    reset = 1'b0; req_valid = 1'b0;
    dresp.data_ok = 1'b1; dresp.data = 64'hFFFF0000FFFF0000;
    @(negedge clk);
    dresp.data_ok = 1'b0;
    chk("late_ok_done", done, 1'b0);
    @(negedge clk);
    chk("late_ok_done2", done, 1'b0);
    chk("late_ok_rdata", rdata, 64'd0);
    model_rdata = 64'd0;

    // back-to-back loads, data_ok on the first BUSY cycle
    do_access(1'b0, 3'b010, 64'h6004, 64'd0, 64'h8765432100000000, 1, 1'b0, d0, v0);
    @(negedge clk);
    do_access(1'b0, 3'b101, 64'h6002, 64'd0, 64'h00000000F00D0000, 1, 1'b0, d1, v1);
    chk("b2b_done_gap", d1 - d0, 3);
    // one idle cycle sits between the first done and the second request's BUSY
    chk("b2b_valid_gap", v1 - d0, 2);
    @(negedge clk);

    // flush while BUSY still completes
    do_access(1'b0, 3'b001, 64'h7002, 64'd0, 64'h00000000BEEF0000, 3, 1'b1, d0, v0);
    @(negedge clk);

    // randomized accesses with idle gaps and stray data_ok while idle
    for (int i = 0; i < 60; i++) begin
      r_addr  = {$urandom(), $urandom()};
      r_wdata = {$urandom(), $urandom()};
      r_resp  = {$urandom(), $urandom()};
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), r_addr, r_wdata,
                r_resp, $urandom_range(1, 4), 1'($urandom_range(0, 5) == 0), d0, v0);
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        dresp.data_ok = 1'b1;
        dresp.data    = {$urandom(), $urandom()};
        @(negedge clk);
        dresp.data_ok = 1'b0;
        chk("idle_ok_done", done, 1'b0);
        chk("idle_ok_rdata", rdata, model_rdata);
      end
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
